// File: rtl/cache_arbiter_pkg.sv
// Shared cache types plus the arbiter's state encoding and requester limit.
package cache_definition;

    localparam int NREQ_MAX = 8;
    localparam int ADDR_W   = 20;
    localparam int DATA_W   = 32;

    // CPU-side request into the cache (also what each requester drives).
    typedef struct packed {
        logic              valid;
        logic              rw;      // 1 = write
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } cpu_to_cache_type;

    // Cache-side response back to the CPU.
    typedef struct packed {
        logic              stopped;
        logic              ready;
        logic [DATA_W-1:0] data;
    } cache_to_cpu_type;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD} arb_state_t;

endpackage

// File: rtl/cache_arbiter_picker.sv
// Rotating-priority encoder: first asserted req at index >= ptr, wrapping.
module rr_picker #(
    parameter  int N  = 2,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          gnt_valid,
    output logic [IW-1:0] gnt_idx
);

    logic [IW:0]   sum;
    logic [IW-1:0] idx;

    // Scan from the farthest position to the nearest so the nearest hit wins.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        sum       = '0;
        idx       = '0;
        for (int k = N - 1; k >= 0; k--) begin
            sum = {1'b0, ptr} + (IW + 1)'(k);
            if (sum >= (IW + 1)'(N))
                sum = sum - (IW + 1)'(N);
            idx = sum[IW-1:0];
            if (req[idx]) begin
                gnt_valid = 1'b1;
                gnt_idx   = idx;
            end
        end
    end

endmodule

// File: rtl/cache_arbiter.sv
// Round-robin arbiter sharing one sa_cache CPU port among NREQ requesters.
// One transaction in flight; read data returns through a one-cycle register.
module cache_arbiter
    import cache_definition::*;
#(
    parameter int NREQ = 2  // 2..NREQ_MAX
) (
    input  logic             clk,
    input  logic             rst,
    input  cpu_to_cache_type req_in  [NREQ],
    output cache_to_cpu_type rsp_out [NREQ],
    output cpu_to_cache_type cpu_to_cache,
    input  cache_to_cpu_type cache_to_cpu
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    arb_state_t           state_q;
    logic [IW-1:0]        rr_q;
    logic [IW-1:0]        owner_q;
    cpu_to_cache_type     req_q;
    logic [NREQ-1:0]      rsp_rdy_q;
    logic [NREQ-1:0][DATA_W-1:0] rsp_data_q;

    logic [NREQ-1:0]      req_vld;
    logic                 gnt_valid;
    logic [IW-1:0]        gnt_idx;
    logic                 accept;
    logic                 done;

    rr_picker #(.N(NREQ)) u_pick (
        .req       (req_vld),
        .ptr       (rr_q),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx)
    );

    // Per-requester fan-out: valid gather, combinational stop, registered reply.
    for (genvar i = 0; i < NREQ; i++) begin : g_lane
        assign req_vld[i]         = req_in[i].valid;
        assign rsp_out[i].stopped = rst || !(state_q == IDLE && gnt_valid &&
                                             gnt_idx == IW'(i));
        assign rsp_out[i].ready   = rsp_rdy_q[i];
        assign rsp_out[i].data    = rsp_data_q[i];
    end

    // The cache only sees a request while we are issuing it.
    assign cpu_to_cache = (state_q == ISSUE) ? req_q : '0;

    // Cache took the request this cycle.
    assign accept = (state_q == ISSUE) && !cache_to_cpu.stopped;

    // Read finished this cycle: either same-cycle hit or later ready pulse.
    assign done = (accept && !req_q.rw && cache_to_cpu.ready) ||
                  (state_q == WAIT_RD && cache_to_cpu.ready);

    // Arbitration / transaction FSM.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            rr_q    <= '0;
            owner_q <= '0;
            req_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    // A ready here would break the cache contract; ignore it.
                    if (gnt_valid) begin
                        req_q   <= req_in[gnt_idx];
                        owner_q <= gnt_idx;
                        rr_q    <= (gnt_idx == IW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
                        state_q <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (accept) begin
                        if (req_q.rw || cache_to_cpu.ready)
                            state_q <= IDLE;
                        else
                            state_q <= WAIT_RD;
                    end
                end
                WAIT_RD: begin
                    if (cache_to_cpu.ready)
                        state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Response register: one-cycle ready to the owner, data held until next reply.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_rdy_q  <= '0;
            rsp_data_q <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                rsp_rdy_q[i] <= done && (owner_q == IW'(i));
                if (done && owner_q == IW'(i))
                    rsp_data_q[i] <= cache_to_cpu.data;
            end
        end
    end

endmodule

// File: tb/tb_cache_arbiter.sv
// Randomized bench for cache_arbiter with a behavioural cache and a
// transaction-level reference (RR pointer, busy flag, reference memory).
module tb_cache_arbiter;
    import cache_definition::*;

    localparam int N = 2;

    logic             clk = 1'b0;
    logic             rst;
    cpu_to_cache_type req_in  [N];
    cache_to_cpu_type rsp_out [N];
    cpu_to_cache_type c2c;
    cache_to_cpu_type cresp;

    cache_arbiter #(.NREQ(N)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_in       (req_in),
        .rsp_out      (rsp_out),
        .cpu_to_cache (c2c),
        .cache_to_cpu (cresp)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    // Backing contents for never-written addresses.
    function automatic logic [31:0] seed(input logic [19:0] a);
        return {12'h5A3, a} ^ 32'h0F0F_1234;
    endfunction

    // Reference memory (updated in grant order) and the cache model's memory.
    logic [31:0] ref_mem [logic [19:0]];
    logic [31:0] cmem    [logic [19:0]];

    // Requester model
    cpu_to_cache_type pend [N];
    int               rem  [N];
    bit               auto_regen = 0;

    // Transaction-level reference
    bit               busy = 0;
    bit               issue_pend = 0;
    cpu_to_cache_type issue_req;
    int               owner = 0;
    int               rr = 0;
    logic [31:0]      exp_rd;
    logic [N-1:0]     exp_rdy = '0;
    logic [31:0]      held [N];
    int               grants[$];
    int               valid_cycles = 0;

    // Cache model knobs/state
    int  lat_fixed = 1;
    int  stall_pct = 0;
    int  stall_force = 0;
    bit  c_pend = 0;
    int  c_cnt = 0;
    logic [19:0] c_addr;

    function automatic cpu_to_cache_type rand_req(input bit allow_idle, input bit reads_only);
        cpu_to_cache_type r;
        r       = '0;
        r.valid = !allow_idle || ($urandom_range(99) < 70);
        r.rw    = !reads_only && ($urandom_range(99) < 35);
        r.addr  = 20'($urandom_range(15) * 4);
        r.data  = $urandom;
        if (!r.valid) r = '0;
        return r;
    endfunction

    // One clock: entered and left at a negedge.
    task automatic cycle();
        logic [N-1:0] got_stop, exp_stop;
        bit           cons, acc, rdy;
        int           ci, lat;
        cons = 0; ci = 0;
        // registered outputs vs reference
        for (int i = 0; i < N; i++) begin
            chk($sformatf("rsp_ready[%0d]", i), 64'(rsp_out[i].ready), 64'(exp_rdy[i]));
            chk($sformatf("rsp_data[%0d]", i), 64'(rsp_out[i].data), 64'(held[i]));
        end
        for (int i = 0; i < N; i++) req_in[i] = pend[i];
        // cache response
        lat   = (lat_fixed >= 0) ? lat_fixed : int'($urandom_range(4));
        cresp = '0;
        if (stall_force > 0) begin
            cresp.stopped = 1'b1;
            stall_force--;
        end else begin
            cresp.stopped = ($urandom_range(99) < stall_pct);
        end
        if (c_pend && c_cnt == 0) begin
            cresp.ready = 1'b1;
            cresp.data  = cmem.exists(c_addr) ? cmem[c_addr] : seed(c_addr);
        end else if (!c_pend && c2c.valid && !c2c.rw && !cresp.stopped && lat == 0) begin
            cresp.ready = 1'b1;
            cresp.data  = cmem.exists(c2c.addr) ? cmem[c2c.addr] : seed(c2c.addr);
        end
        #1;
        // combinational outputs vs reference
        chk("cpu_to_cache", 64'(c2c), issue_pend ? 64'(issue_req) : 64'(0));
        exp_stop = '1;
        if (!rst && !busy) begin
            for (int k = 0; k < N; k++) begin
                int j;
                j = (rr + k) % N;
                if (pend[j].valid) begin
                    exp_stop[j] = 1'b0;
                    break;
                end
            end
        end
        for (int i = 0; i < N; i++) got_stop[i] = rsp_out[i].stopped;
        chk("stopped", 64'(got_stop), 64'(exp_stop));
        for (int i = 0; i < N; i++)
            if (pend[i].valid && !rsp_out[i].stopped) begin cons = 1; ci = i; end
        if (c2c.valid) valid_cycles++;
        acc = c2c.valid && !cresp.stopped;
        rdy = cresp.ready;
        @(posedge clk);
        if (rst) begin
            busy = 0; issue_pend = 0; rr = 0; exp_rdy = '0; c_pend = 0;
            for (int i = 0; i < N; i++) held[i] = '0;
        end else begin
            exp_rdy = '0;
            if (rdy && busy) begin
                exp_rdy[owner] = 1'b1;
                held[owner]    = exp_rd;
                busy           = 0;
            end
            if (c_pend) begin
                if (rdy) c_pend = 0;
                else     c_cnt--;
            end
            if (acc) begin
                issue_pend = 0;
                if (c2c.rw) begin
                    cmem[c2c.addr] = c2c.data;
                    busy = 0;
                end else if (!rdy) begin
                    c_pend = 1; c_cnt = lat - 1; c_addr = c2c.addr;
                end
            end
            if (cons) begin
                busy = 1; issue_pend = 1;
                issue_req = pend[ci]; issue_req.valid = 1'b1;
                owner = ci; rr = (ci + 1) % N;
                grants.push_back(ci);
                if (pend[ci].rw) ref_mem[pend[ci].addr] = pend[ci].data;
                else exp_rd = ref_mem.exists(pend[ci].addr) ? ref_mem[pend[ci].addr] : seed(pend[ci].addr);
                if (rem[ci] > 0) begin
                    rem[ci]--;
                    pend[ci] = rand_req(0, 1);
                end else if (auto_regen) begin
                    pend[ci] = rand_req(1, 0);
                end else begin
                    pend[ci] = '0;
                end
            end
        end
        @(negedge clk);
    endtask

    // Run until every requester is quiet and the reference is idle.
    task automatic drain();
        bit ok;
        ok = 0;
        for (int n = 0; n < 300; n++) begin
            bit any;
            any = 0;
            for (int i = 0; i < N; i++) any |= pend[i].valid;
            if (!any && !busy && !issue_pend) begin ok = 1; break; end
            cycle();
        end
        chk("drain_timeout", 64'(ok), 64'(1));
        cycle();
        cycle();
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        for (int k = 0; k < n; k++) cycle();
        rst = 1'b0;
    endtask

    initial begin
        bit hit;
        rst   = 1'b1;
        cresp = '0;
        for (int i = 0; i < N; i++) begin
            pend[i] = '0; req_in[i] = '0; rem[i] = 0; held[i] = '0;
        end
        ref_mem[20'h00010] = 32'hDEADBEEF;
        cmem[20'h00010]    = 32'hDEADBEEF;
        @(posedge clk);
        @(negedge clk);
        do_reset(3);
        cycle();

        // single read, cache ready 3 cycles after accept
        lat_fixed = 3;
        pend[0]   = '{valid: 1'b1, rw: 1'b0, addr: 20'h00010, data: 32'h0};
        drain();
        chk("single_rd_data", 64'(rsp_out[0].data), 64'h0DEADBEEF);

        // simultaneous reads at reset exit: strict alternation r0,r1,...
        lat_fixed = -1;
        rst = 1'b1;
        cycle();
        for (int i = 0; i < N; i++) begin
            pend[i] = rand_req(0, 1);
            rem[i]  = 3;
        end
        cycle();
        rst = 1'b0;
        grants.delete();
        drain();
        chk("rr_count", 64'(grants.size()), 64'(8));
        for (int k = 0; k < grants.size() && k < 8; k++)
            chk($sformatf("rr_order[%0d]", k), 64'(grants[k]), 64'(k % 2));

        // write by r1, then read by r0
        lat_fixed = 1;
        pend[1] = '{valid: 1'b1, rw: 1'b1, addr: 20'h00100, data: 32'h12345678};
        drain();
        pend[0] = '{valid: 1'b1, rw: 1'b0, addr: 20'h00100, data: 32'h0};
        drain();
        chk("wr_rd_data", 64'(rsp_out[0].data), 64'h12345678);

        // cache stall: grant cycle + 5 stalled ISSUE cycles, accept on the 6th
        valid_cycles = 0;
        stall_force  = 6;
        lat_fixed    = 0;
        pend[0] = '{valid: 1'b1, rw: 1'b0, addr: 20'h00010, data: 32'h0};
        drain();
        chk("stall_issue_cycles", 64'(valid_cycles), 64'(6));

        // reset while waiting for read data
        lat_fixed = 6;
        pend[0] = '{valid: 1'b1, rw: 1'b0, addr: 20'h00020, data: 32'h0};
        hit = 0;
        for (int n = 0; n < 20; n++) begin
            cycle();
            if (c_pend) begin hit = 1; break; end
        end
        chk("reach_wait_rd", 64'(hit), 64'(1));
        do_reset(1);
        chk("rst_rsp_data0", 64'(rsp_out[0].data), 64'(0));
        lat_fixed = 2;
        pend[1] = '{valid: 1'b1, rw: 1'b0, addr: 20'h00010, data: 32'h0};
        drain();
        chk("post_rst_data", 64'(rsp_out[1].data), 64'h0DEADBEEF);

        // random regression
        lat_fixed  = -1;
        stall_pct  = 30;
        auto_regen = 1;
        for (int i = 0; i < N; i++) pend[i] = rand_req(1, 0);
        for (int n = 0; n < 3000; n++) cycle();
        auto_regen = 0;
        stall_pct  = 0;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
